// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the unified memory: latches one winner,
// issues it to memory, and returns registered read data after RD_LAT cycles.
//
// state | meaning
// IDLE  | no transaction in flight; sample requests and pick a winner
// ISSUE | drive latched command to memory; winner's gnt high
// WAIT  | read in flight; count down from RD_LAT, capture mem_rd at count 1
module mem_arbiter #(
  parameter int WIDTH  = 32,
  parameter int RD_LAT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic             m0_we,
  input  logic             m1_we,
  input  logic [WIDTH-1:0] m0_adr,
  input  logic [WIDTH-1:0] m1_adr,
  input  logic [WIDTH-1:0] m0_wd,
  input  logic [WIDTH-1:0] m1_wd,
  output logic             m0_gnt,
  output logic             m1_gnt,
  output logic             m0_rvalid,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             win_q, win_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] adr_q, adr_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             rv0_q, rv0_d;
  logic             rv1_q, rv1_d;
  logic             pick;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    // on a tie the port that did not win last time goes first
    pick    = (m0_req && m1_req) ? ~last_q : m1_req;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          win_d   = pick;
          last_d  = pick;
          we_d    = pick ? m1_we  : m0_we;
          adr_d   = pick ? m1_adr : m0_adr;
          wd_d    = pick ? m1_wd  : m0_wd;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else if (LAT == 3'd0) begin
          rdata_d = mem_rd;
          rv0_d   = ~win_q;
          rv1_d   = win_q;
          state_d = IDLE;
        end else begin
          cnt_d   = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          rdata_d = mem_rd;
          rv0_d   = ~win_q;
          rv1_d   = win_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= 3'd0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  // mem_we is decoded from state so an async reset removes it without a clock
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign m0_gnt    = (state_q == ISSUE) && !win_q;
  assign m1_gnt    = (state_q == ISSUE) && win_q;
  assign busy      = (state_q != IDLE);
  assign mem_adr   = adr_q;
  assign mem_wd    = wd_q;
  assign rdata     = rdata_q;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: randomized rounds against an ordered transaction model,
// scoreboard-checked by a negedge monitor, plus a zero-latency instance.
module tb_mem_arbiter;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         m0_req, m1_req, m0_we, m1_we;
  logic [W-1:0] m0_adr, m1_adr, m0_wd, m1_wd;
  logic         m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, busy;
  logic [W-1:0] rdata, mem_adr, mem_wd, mem_rd;

  logic         z0_req, z1_req, z0_we, z1_we;
  logic [W-1:0] z0_adr, z1_adr, z0_wd, z1_wd;
  logic         z0_gnt, z1_gnt, z0_rvalid, z1_rvalid, z_mem_we, z_busy;
  logic [W-1:0] z_rdata, z_mem_adr, z_mem_wd, z_mem_rd;

  mem_arbiter #(.WIDTH(W), .RD_LAT(LAT)) u_dut (
    .clk(clk), .reset(rst_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_adr(m0_adr), .m1_adr(m1_adr), .m0_wd(m0_wd), .m1_wd(m1_wd),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd), .busy(busy)
  );

  mem_arbiter #(.WIDTH(W), .RD_LAT(0)) u_dut0 (
    .clk(clk), .reset(rst_n),
    .m0_req(z0_req), .m1_req(z1_req), .m0_we(z0_we), .m1_we(z1_we),
    .m0_adr(z0_adr), .m1_adr(z1_adr), .m0_wd(z0_wd), .m1_wd(z1_wd),
    .m0_gnt(z0_gnt), .m1_gnt(z1_gnt), .m0_rvalid(z0_rvalid), .m1_rvalid(z1_rvalid),
    .rdata(z_rdata), .mem_adr(z_mem_adr), .mem_wd(z_mem_wd), .mem_we(z_mem_we),
    .mem_rd(z_mem_rd), .busy(z_busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] init_word(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // memory device: combinational read, write at the clock edge
  logic [W-1:0] mem [256];
  logic         mem_ready = 1'b0;
  assign mem_rd   = mem[mem_adr[9:2]];
  assign z_mem_rd = init_word(z_mem_adr);
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(32'(i * 4));
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_adr[9:2]] <= mem_wd;
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // reference model: transactions are serialized, so memory is an ordered map
  typedef struct { bit port; bit we; logic [W-1:0] adr; logic [W-1:0] wd; int cyc; } gexp_t;
  typedef struct { bit port; logic [W-1:0] data; int cyc; } rexp_t;
  gexp_t        gq[$];
  rexp_t        rq[$];
  logic [W-1:0] ref_mem [logic [W-1:0]];
  bit           last_win = 1'b1;
  logic [W-1:0] exp_adr = '0;
  logic [W-1:0] exp_wd  = '0;

  function automatic logic [W-1:0] ref_read(input logic [W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  gexp_t g;
  rexp_t r;
  always @(negedge clk) begin
    if (rst_n) begin
      if (gq.size() != 0 && gq[0].cyc == cyc) begin
        g = gq.pop_front();
        check("gnt0", m0_gnt, !g.port);
        check("gnt1", m1_gnt, g.port);
        check("mem_we_issue", mem_we, g.we);
        check("mem_adr_issue", mem_adr, g.adr);
        check("mem_wd_issue", mem_wd, g.wd);
        check("busy_issue", busy, 1);
        exp_adr = g.adr;
        exp_wd  = g.wd;
      end else begin
        check("gnt_quiet", m0_gnt | m1_gnt, 0);
        check("mem_we_quiet", mem_we, 0);
        check("mem_adr_hold", mem_adr, exp_adr);
        check("mem_wd_hold", mem_wd, exp_wd);
      end
      if (rq.size() != 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        check("rvalid0", m0_rvalid, !r.port);
        check("rvalid1", m1_rvalid, r.port);
        check("rdata", rdata, r.data);
      end else begin
        check("rvalid_quiet", m0_rvalid | m1_rvalid, 0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic do_round(input bit a0, input bit a1, input bit we0, input bit we1,
                          input logic [W-1:0] ad0, input logic [W-1:0] ad1,
                          input logic [W-1:0] wd0, input logic [W-1:0] wd1);
    bit    order[2];
    int    cnt, t, n;
    bit    p0, p1, p;
    gexp_t e;
    rexp_t x;
    wait_idle();
    m0_req = a0; m0_we = we0; m0_adr = ad0; m0_wd = wd0;
    m1_req = a1; m1_we = we1; m1_adr = ad1; m1_wd = wd1;
    t = cyc + 1;
    if (a0 && a1) begin
      order[0] = !last_win; order[1] = last_win; cnt = 2;
    end else begin
      order[0] = a1; order[1] = a1; cnt = 1;
    end
    for (int i = 0; i < cnt; i++) begin
      p     = order[i];
      e.port = p;
      e.we   = p ? we1 : we0;
      e.adr  = p ? ad1 : ad0;
      e.wd   = p ? wd1 : wd0;
      e.cyc  = t;
      gq.push_back(e);
      if (e.we) begin
        ref_mem[e.adr] = e.wd;
        t += 2;
      end else begin
        x.port = p; x.data = ref_read(e.adr); x.cyc = t + LAT + 1;
        rq.push_back(x);
        t += LAT + 2;
      end
      last_win = p;
    end
    p0 = a0; p1 = a1; n = 0;
    while ((p0 || p1) && n < 60) begin
      @(negedge clk);
      n++;
      if (p0 && m0_gnt) begin
        p0 = 0; m0_req = 0; m0_we = 1'($urandom); m0_adr = $urandom; m0_wd = $urandom;
      end
      if (p1 && m1_gnt) begin
        p1 = 0; m1_req = 0; m1_we = 1'($urandom); m1_adr = $urandom; m1_wd = $urandom;
      end
    end
    check("gnt_timeout", {30'd0, p0, p1}, 0);
  endtask

  task automatic rand_round();
    bit a0, a1;
    a0 = 1'($urandom);
    a1 = 1'($urandom);
    if (!a0 && !a1) a0 = 1;
    do_round(a0, a1, 1'($urandom), 1'($urandom),
             32'($urandom_range(0, 255)) << 2, 32'($urandom_range(0, 255)) << 2,
             $urandom, $urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, {30'd0, m0_gnt, m1_gnt}, 0);
    check({tag, "_rvalid"}, {30'd0, m0_rvalid, m1_rvalid}, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_adr"}, mem_adr, 0);
    check({tag, "_mem_wd"}, mem_wd, 0);
    check({tag, "_rdata"}, rdata, 0);
  endtask

  task automatic reset_now(input string tag);
    #2 rst_n = 0;
    #1 check_reset_outputs(tag);
    gq.delete();
    rq.delete();
    exp_adr = '0;
    exp_wd  = '0;
    last_win = 1'b1;
    m0_req = 0; m1_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // issue one transaction by hand and return at the negedge of its grant
  task automatic issue_single(input bit port, input bit we, input logic [W-1:0] adr,
                              input logic [W-1:0] wd);
    gexp_t e;
    int    n = 0;
    wait_idle();
    if (port) begin m1_req = 1; m1_we = we; m1_adr = adr; m1_wd = wd; end
    else      begin m0_req = 1; m0_we = we; m0_adr = adr; m0_wd = wd; end
    e.port = port; e.we = we; e.adr = adr; e.wd = wd; e.cyc = cyc + 1;
    gq.push_back(e);
    last_win = port;
    do begin
      @(negedge clk);
      n++;
    end while (!(m0_gnt || m1_gnt) && n < 20);
    check("single_gnt_seen", m0_gnt | m1_gnt, 1);
    m0_req = 0; m1_req = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit           zp;
    logic [W-1:0] za;
    rst_n = 0;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_adr = '0; m1_adr = '0; m0_wd = '0; m1_wd = '0;
    z0_req = 0; z1_req = 0; z0_we = 0; z1_we = 0;
    z0_adr = '0; z1_adr = '0; z0_wd = '0; z1_wd = '0;
    #2 check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1;

    do_round(1, 0, 1, 0, 32'h40, 32'h0, 32'hDEAD_BEEF, 32'h0);
    do_round(1, 0, 1, 0, 32'h80, 32'h0, 32'h1234_5678, 32'h0);
    do_round(0, 1, 0, 0, 32'h0, 32'h80, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++)
      do_round(1, 1, 0, 0, 32'(16 * i), 32'(16 * i + 4), $urandom, $urandom);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      rand_round();
    end

    // abort a read while it waits on memory latency
    issue_single(1, 0, 32'h100, 32'h0);
    @(negedge clk);
    check("wait_busy", busy, 1);
    reset_now("rst_wait");
    do_round(1, 1, 0, 0, 32'h0C, 32'h40, 32'h0, 32'h0);

    // abort a write in its issue cycle; mem_we must fall without a clock
    issue_single(0, 1, 32'h200, 32'hCAFE_F00D);
    #1 rst_n = 0;
    #1 check("rst_issue_mem_we", mem_we, 0);
    reset_now("rst_issue");
    do_round(0, 1, 0, 0, 32'h0, 32'h200, 32'h0, 32'h0);

    for (int i = 0; i < 20; i++) rand_round();
    wait_idle();
    repeat (LAT + 3) @(negedge clk);
    check("sb_drain", 32'(gq.size() + rq.size()), 0);

    // zero-latency instance: both ports reading continuously
    z0_req = 1; z1_req = 1; z0_adr = 32'h0C; z1_adr = 32'(4 * $urandom_range(0, 255));
    zp = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("z_gnt0", z0_gnt, !zp);
      check("z_gnt1", z1_gnt, zp);
      za = zp ? z1_adr : z0_adr;
      check("z_mem_adr", z_mem_adr, za);
      check("z_mem_we", z_mem_we, 0);
      if (zp) z1_adr = 32'(4 * $urandom_range(0, 255));
      else    z0_adr = 32'(4 * $urandom_range(0, 255));
      @(negedge clk);
      check("z_rvalid0", z0_rvalid, !zp);
      check("z_rvalid1", z1_rvalid, zp);
      check("z_rdata", z_rdata, init_word(za));
      check("z_gnt_gap", z0_gnt | z1_gnt, 0);
      zp = !zp;
    end
    z0_req = 0; z1_req = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single unified instruction/data memory between the multicycle MIPS core (port 0) and a second bus master such as a program loader or debug/DMA engine (port 1). It uses round-robin arbitration and latches the winning request. It then drives the memory address, write-data and write-enable lines for a fixed, parameterised read latency, and returns registered read data with a per-port valid pulse. It sits between the core's `adr`/`writedata`/`memwrite`/`readdata` lines and the memory model.

## Interface
Parameters:
- `WIDTH`, 32: address and data width.
- `RD_LAT`, 0: memory read latency in cycles, legal range 0–7. 0 means a combinational read.

Ports:
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `m0_req`, `m1_req`, input, 1: transaction request from port 0 / port 1.
- `m0_we`, `m1_we`, input, 1: 1 = write, 0 = read.
- `m0_adr`, `m1_adr`, input, WIDTH: byte address.
- `m0_wd`, `m1_wd`, input, WIDTH: write data.
- `m0_gnt`, `m1_gnt`, output, 1: one-cycle pulse in the issue cycle of that port's transaction.
- `m0_rvalid`, `m1_rvalid`, output, 1: one-cycle read-data-valid pulse.
- `rdata`, output, WIDTH: registered read data, shared by both ports, qualified by `mX_rvalid`.
- `mem_adr`, output, WIDTH: memory address.
- `mem_wd`, output, WIDTH: memory write data.
- `mem_we`, output, 1: memory write enable.
- `mem_rd`, input, WIDTH: memory read data.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT.
- **IDLE:**
  - If any `mX_req` is high, select a winner and latch its `we`, `adr` and `wd`. Record the winner. Go to ISSUE.
  - Otherwise stay in IDLE.
- **Arbitration:**
  - Exactly one request high: that port wins.
  - Both high: the port that did not win last wins.
  - After reset, the last winner is port 1, so port 0 wins the first tie.
- **ISSUE (one cycle):**
  - `mem_adr` and `mem_wd` drive the latched values.
  - `mem_we` equals the latched `we`.
  - The winner's `gnt` is high.
  - Write: next state is IDLE.
  - Read with `RD_LAT` = 0: capture `mem_rd` into `rdata` and go to IDLE.
  - Read with `RD_LAT` > 0: load the latency counter with `RD_LAT` and go to WAIT.
- **WAIT:**
  - `mem_adr` is held and `mem_we` = 0.
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, capture `mem_rd` into `rdata` and go to IDLE.
- **Read response:** the winner's `rvalid` pulses exactly one cycle, in the cycle after capture.
- **`rdata` hold:** `rdata` keeps its value until the next capture.
- **`mem_we` scope:** `mem_we` is high only in ISSUE, never in IDLE or WAIT.
- **`mem_adr`/`mem_wd` in IDLE:** both hold their last driven values. They do not follow the request inputs.
- **Requester rules:**
  - Hold `req`, `we`, `adr` and `wd` stable until `gnt` is seen.
  - Drop `req` in the cycle after `gnt` unless a new transaction is wanted. A held `req` is treated as a new request.
- **Late request changes:**
  - Requests are sampled only in IDLE.
  - Once a request is latched, dropping `req` or changing inputs has no effect; the transaction completes.
- **Out-of-range `RD_LAT`:** values above 7 are illegal. The bench does not cover them.

## Timing
- **Reset values:**
  - State = IDLE; last winner = port 1.
  - All `gnt`, `rvalid`, `mem_we` and `busy` = 0.
  - `mem_adr`, `mem_wd` and `rdata` = 0.
- **Reset mid-transaction:**
  - Any in-flight transaction is aborted immediately and asynchronously.
  - No `rvalid` is ever emitted for it.
  - `mem_we` drops to 0 at the reset edge, without waiting for `clk`.
- **Write:** request seen in IDLE at cycle t−1; ISSUE at t (`mem_we`, `gnt`); IDLE at t+1. Throughput is one write every 2 cycles.
- **Read:**
  - ISSUE at t.
  - `mem_adr` is stable from t through t+`RD_LAT`.
  - `mem_rd` is sampled at the end of t+`RD_LAT`.
  - `rvalid` fires at t+`RD_LAT`+1, in the same cycle the FSM is back in IDLE and may accept the next request.
- **Simultaneous events:** a new request in the `rvalid` cycle is arbitrated normally. Its ISSUE occurs at t+`RD_LAT`+2.

## Test plan
- **Reset:** assert `reset`=0 mid-run → all outputs 0 and `busy`=0. The first tie after release is granted to port 0.
- **Port 0 write:** `m0_we`=1, `m0_adr`=0x40, `m0_wd`=0xDEADBEEF → exactly one cycle with `mem_we`=1, `mem_adr`=0x40, `mem_wd`=0xDEADBEEF and `m0_gnt`=1. `m1_gnt` stays 0 and no `rvalid` fires.
- **Port 1 read, `RD_LAT`=2:** model returns 0x12345678 at t+2 → `mem_adr` stable t..t+2, then `m1_rvalid`=1 with `rdata`=0x12345678 at t+3 only. `m0_rvalid` stays 0.
- **Both ports requesting continuously (reads, `RD_LAT`=0):** grants alternate m0, m1, m0, m1. Each `rdata` matches its own address contents.
- **Reset during WAIT (`RD_LAT`=3):** no `rvalid`, FSM back to IDLE. The next port 0 read completes correctly at t+4.
- **`RD_LAT`=0 read of 0x0000000C:** `m0_rvalid` at t+1 with memory word 0x0C. A back-to-back request issues at t+2.
